// File: rtl/gmm_fg_joiner.sv
// Joins the live RGB888 Avalon-ST video stream with the per-pixel GMM model stream
// into {is_fg, mem_pixel, new_pixel} words for the foreground visor stage.
module gmm_fg_joiner #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int CNT_W  = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_valid,
  input  logic        vid_sop,
  input  logic        vid_eop,
  input  logic [23:0] vid_data,
  output logic        vid_ready,
  input  logic        mdl_valid,
  input  logic [24:0] mdl_data,
  output logic        mdl_ready,
  input  logic        src_ready,
  output logic        src_valid,
  output logic        src_sop,
  output logic        src_eop,
  output logic [48:0] src_data,
  input  logic        err_clr,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, CTRL = 2'd1, VIDEO = 2'd2} state_t;

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(WIDTH * HEIGHT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic              src_valid_q, src_valid_d;
  logic              src_sop_q, src_sop_d;
  logic              src_eop_q, src_eop_d;
  logic [48:0]       src_data_q, src_data_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              adv, vid_xfer;
  logic              accept, joined, take_sop, set_short, set_long;
  logic [1:0]        frame_inc;

  assign adv         = src_ready | ~src_valid_q;
  assign pix_cnt_inc = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + CNT_W'(1);

  // Pixels only move when both streams can transfer together; sop words never pull model data.
  always_comb begin
    vid_ready = adv;
    mdl_ready = 1'b0;
    if (state_q == VIDEO && !vid_sop) begin
      vid_ready = adv & mdl_valid;
      mdl_ready = adv & vid_valid;
    end
  end

  assign vid_xfer = vid_valid & vid_ready;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    accept      = 1'b0;
    joined      = 1'b0;
    take_sop    = 1'b0;
    set_short   = 1'b0;
    set_long    = 1'b0;
    frame_inc   = 2'd0;
    src_valid_d = src_valid_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    src_data_d  = src_data_q;

    case (state_q)
      IDLE: begin
        if (vid_xfer && vid_sop) begin
          accept   = 1'b1;
          take_sop = 1'b1;
        end
      end
      CTRL: begin
        if (vid_xfer) begin
          accept = 1'b1;
          if (vid_eop) state_d = IDLE;
        end
      end
      VIDEO: begin
        if (vid_xfer) begin
          accept = 1'b1;
          if (vid_sop) begin
            // A new packet cut the frame short: close it out, then decode the new header.
            take_sop  = 1'b1;
            set_short = 1'b1;
            frame_inc = 2'd1;
          end else begin
            joined    = 1'b1;
            pix_cnt_d = pix_cnt_inc;
            if (vid_eop) begin
              set_short = (pix_cnt_inc < PIX_TOTAL);
              set_long  = (pix_cnt_inc > PIX_TOTAL);
              frame_inc = 2'd1;
              state_d   = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_sop) begin
      if (vid_data[3:0] == 4'h0) begin
        pix_cnt_d = '0;
        if (vid_eop) begin
          state_d   = IDLE;
          set_short = 1'b1;
          frame_inc = frame_inc + 2'd1;
        end else begin
          state_d = VIDEO;
        end
      end else begin
        state_d = vid_eop ? IDLE : CTRL;
      end
    end

    if (accept) begin
      src_valid_d = 1'b1;
      src_sop_d   = vid_sop;
      src_eop_d   = vid_eop;
      src_data_d  = joined ? {mdl_data, vid_data} : {25'h0, vid_data};
    end else if (src_ready) begin
      src_valid_d = 1'b0;
    end
  end

  assign err_short_d = (err_short_q & ~err_clr) | set_short;
  assign err_long_d  = (err_long_q & ~err_clr) | set_long;
  assign frame_cnt_d = frame_cnt_q + {14'h0, frame_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_data_q  <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      src_data_q  <= src_data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign src_valid = src_valid_q;
  assign src_sop   = src_sop_q;
  assign src_eop   = src_eop_q;
  assign src_data  = src_data_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gmm_fg_joiner.sv
// Scoreboard bench for gmm_fg_joiner on a 4x2 frame: expected output words are queued
// as stimulus is driven and compared in order as the DUT hands them downstream.
module tb_gmm_fg_joiner;

  localparam int W = 4;
  localparam int H = 2;
  localparam logic [23:0] HDR = 24'h5A5A50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vid_valid, vid_sop, vid_eop, vid_ready;
  logic [23:0] vid_data;
  logic        mdl_valid, mdl_ready;
  logic [24:0] mdl_data;
  logic        src_ready, src_valid, src_sop, src_eop;
  logic [48:0] src_data;
  logic        err_clr, err_short, err_long;
  logic [15:0] frame_cnt;

  gmm_fg_joiner #(.WIDTH(W), .HEIGHT(H), .CNT_W(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_valid(vid_valid), .vid_sop(vid_sop), .vid_eop(vid_eop), .vid_data(vid_data),
    .vid_ready(vid_ready),
    .mdl_valid(mdl_valid), .mdl_data(mdl_data), .mdl_ready(mdl_ready),
    .src_ready(src_ready), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_data(src_data),
    .err_clr(err_clr), .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int          cycleCount = 0;
  int          expFrames = 0;
  logic [50:0] expQ[$];
  logic [24:0] mdlQ[$];
  int          xferCyc[$];
  logic        mdlGaps = 1'b0;
  logic        readyToggle = 1'b0;
  logic        watchMdl = 1'b0;
  logic        sawMdlReady = 1'b0;
  logic        watchIdle = 1'b0;
  logic        sawValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic s, input logic l);
    checkOutput(tag, {46'h0, err_short, err_long, frame_cnt}, {46'h0, s, l, 16'(expFrames)});
  endtask

  function automatic logic [24:0] mdlWord(input int k);
    return {1'(k % 2), 24'h112233 + 24'(k * 32'h010101)};
  endfunction

  // Drives one video word and holds it until the DUT takes it; optionally queues the expected output.
  task automatic applyStimulus(input logic [23:0] d, input logic s, input logic e,
                               input logic expectOut, input logic [48:0] expData);
    logic took = 1'b0;
    vid_data  = d;
    vid_sop   = s;
    vid_eop   = e;
    vid_valid = 1'b1;
    if (expectOut) expQ.push_back({s, e, expData});
    for (int n = 0; n < 300 && !took; n++) begin
      @(negedge clk);
      took = vid_ready;
      @(posedge clk);
      #1;
    end
    vid_valid = 1'b0;
    vid_sop   = 1'b0;
    vid_eop   = 1'b0;
    if (!took) checkOutput("vid_handshake", {63'h0, took}, 64'h1);
  endtask

  task automatic sendFrame(input int npix, input logic [23:0] base, input logic withEop);
    logic [23:0] v;
    for (int k = 0; k < npix; k++) mdlQ.push_back(mdlWord(k));
    applyStimulus(HDR, 1'b1, 1'b0, 1'b1, {25'h0, HDR});
    for (int k = 0; k < npix; k++) begin
      v = base + 24'(k);
      applyStimulus(v, 1'b0, withEop && (k == npix - 1), 1'b1, {mdlWord(k), v});
    end
  endtask

  // Returns on a negedge once every queued word has left the DUT.
  task automatic waitDrain(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expQ.size() != 0 || src_valid) && n < 400);
    if (expQ.size() != 0 || src_valid)
      checkOutput(tag, {31'h0, src_valid, 32'(expQ.size())}, 64'h0);
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Output monitor: every downstream transfer must match the head of the scoreboard.
  initial begin
    logic [50:0] expWord;
    forever begin
      @(negedge clk);
      cycleCount++;
      if (watchMdl && mdl_ready) sawMdlReady = 1'b1;
      if (watchIdle && src_valid) sawValid = 1'b1;
      if (rst_n && src_valid && src_ready) begin
        xferCyc.push_back(cycleCount);
        if (expQ.size() == 0) begin
          checkOutput("spurious_word", {1'b1, 12'h0, src_sop, src_eop, src_data}, 64'h0);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("out_word", {13'h0, src_sop, src_eop, src_data}, {13'h0, expWord});
        end
      end
    end
  end

  // Model stream source, optionally idling on alternate cycles.
  initial begin
    logic mx;
    logic phase;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    phase     = 1'b0;
    forever begin
      @(negedge clk);
      mx = mdl_valid & mdl_ready;
      @(posedge clk);
      #1;
      if (mx && mdlQ.size() > 0) void'(mdlQ.pop_front());
      phase = ~phase;
      if (mdlQ.size() > 0 && !(mdlGaps && phase)) begin
        mdl_valid = 1'b1;
        mdl_data  = mdlQ[0];
      end else begin
        mdl_valid = 1'b0;
      end
    end
  end

  // Downstream backpressure.
  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_ready = readyToggle ? ~src_ready : 1'b1;
    end
  end

  initial begin
    #300000;
    compared++;
    mismatched++;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc;
    rst_n = 1'b1;
    vid_valid = 1'b0; vid_sop = 1'b0; vid_eop = 1'b0; vid_data = '0;
    err_clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    checkOutput("reset_src", {12'h0, src_valid, src_sop, src_eop, src_data}, 64'h0);
    checkStatus("reset_status", 1'b0, 1'b0);
    checkOutput("reset_ready", {62'h0, vid_ready, mdl_ready}, 64'h2);
    toDrive();

    $display("[TB] control packet");
    watchMdl = 1'b1;
    sawMdlReady = 1'b0;
    applyStimulus(24'h12345F, 1'b1, 1'b0, 1'b1, {25'h0, 24'h12345F});
    applyStimulus(24'hABCDE0, 1'b0, 1'b0, 1'b1, {25'h0, 24'hABCDE0});
    applyStimulus(24'h654321, 1'b0, 1'b1, 1'b1, {25'h0, 24'h654321});
    waitDrain("ctrl_drain");
    watchMdl = 1'b0;
    checkOutput("ctrl_mdl_ready", {63'h0, sawMdlReady}, 64'h0);
    checkStatus("ctrl_status", 1'b0, 1'b0);
    toDrive();

    $display("[TB] full frame, no backpressure");
    xferCyc.delete();
    startCyc = cycleCount;
    sendFrame(8, 24'h400000, 1'b1);
    expFrames = 1;
    waitDrain("frame1_drain");
    checkStatus("frame1_status", 1'b0, 1'b0);
    checkOutput("frame1_count", 64'(xferCyc.size()), 64'd9);
    checkOutput("frame1_latency", 64'(xferCyc.size() > 0 ? xferCyc[0] - startCyc : -1), 64'd2);
    checkOutput("frame1_b2b", 64'(xferCyc.size() >= 9 ? xferCyc[8] - xferCyc[0] : -1), 64'd8);
    toDrive();

    $display("[TB] full frame, model gaps and backpressure");
    mdlGaps = 1'b1;
    readyToggle = 1'b1;
    sendFrame(8, 24'h500000, 1'b1);
    expFrames = 2;
    waitDrain("frame2_drain");
    readyToggle = 1'b0;
    mdlGaps = 1'b0;
    checkStatus("frame2_status", 1'b0, 1'b0);
    toDrive();

    $display("[TB] short then long frame");
    sendFrame(6, 24'h600000, 1'b1);
    expFrames = 3;
    waitDrain("short_drain");
    checkStatus("short_status", 1'b1, 1'b0);
    toDrive();
    pulseClear();
    @(negedge clk);
    checkStatus("short_cleared", 1'b0, 1'b0);
    toDrive();
    sendFrame(10, 24'h610000, 1'b1);
    expFrames = 4;
    waitDrain("long_drain");
    checkStatus("long_status", 1'b0, 1'b1);
    toDrive();
    pulseClear();

    $display("[TB] stray words while idle");
    watchIdle = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(24'hAAAAAA, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    watchIdle = 1'b0;
    checkOutput("idle_discard", {63'h0, sawValid}, 64'h0);
    toDrive();
    sendFrame(8, 24'h800000, 1'b1);
    expFrames = 5;
    waitDrain("frame5_drain");
    checkStatus("frame5_status", 1'b0, 1'b0);
    toDrive();

    $display("[TB] early sop");
    sendFrame(2, 24'h700000, 1'b0);
    sendFrame(8, 24'h710000, 1'b1);
    expFrames = 7;
    waitDrain("early_drain");
    checkStatus("early_status", 1'b1, 1'b0);
    toDrive();
    pulseClear();

    $display("[TB] reset mid frame");
    sendFrame(3, 24'h900000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", {63'h0, src_valid}, 64'h0);
    checkOutput("rst_async_status", {46'h0, err_short, err_long, frame_cnt}, 64'h0);
    expQ.delete();
    mdlQ.delete();
    expFrames = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    watchIdle = 1'b1;
    sawValid = 1'b0;
    for (int k = 3; k < 8; k++) applyStimulus(24'h900000 + 24'(k), 1'b0, k == 7, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    watchIdle = 1'b0;
    checkOutput("rst_discard", {63'h0, sawValid}, 64'h0);
    toDrive();
    sendFrame(8, 24'hA00000, 1'b1);
    expFrames = 1;
    waitDrain("post_rst_drain");
    checkStatus("post_rst_status", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
